// File: rtl/grid_diff_scanner_pkg.sv
// Shared types for the grid diff scanner: tile codes and scanner FSM states.
package grid_pkg;

    // Native width of the tile code enum; the top zero-extends to CODE_W.
    localparam int CODE_BASE_W = 3;

    typedef enum logic [CODE_BASE_W-1:0] {
        CODE_EMPTY    = 3'd0,
        CODE_BODY     = 3'd1,
        CODE_HEAD     = 3'd2,
        CODE_APPLE    = 3'd3,
        CODE_BORDER   = 3'd4,
        CODE_GAMEOVER = 3'd5,
        CODE_INVALID  = 3'd7
    } tile_code_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT_CMD,
        FRAME_END
    } scan_state_t;

endpackage

// File: rtl/grid_diff_scanner_tile_encoder.sv
// Priority encoder from the object-decoder flags to a tile code.
// CODE_INVALID is never produced here; the frame buffer uses it as "unknown".
module tile_encoder
    import grid_pkg::*;
(
    input  logic       i_snake_body,
    input  logic       i_snake_head,
    input  logic       i_apple,
    input  logic       i_border,
    input  logic       i_game_over,
    output tile_code_t o_code
);

    // Game-over fill paints every non-border tile; otherwise the head wins over body, apple, border.
    always_comb begin
        if (i_game_over && !i_border) begin
            o_code = CODE_GAMEOVER;
        end else if (i_snake_head) begin
            o_code = CODE_HEAD;
        end else if (i_snake_body) begin
            o_code = CODE_BODY;
        end else if (i_apple) begin
            o_code = CODE_APPLE;
        end else if (i_border) begin
            o_code = CODE_BORDER;
        end else begin
            o_code = CODE_EMPTY;
        end
    end

endmodule

// File: rtl/grid_diff_scanner.sv
// Raster-scans a GRID_W x GRID_H tile grid, compares each encoded tile against a
// frame buffer and hands only changed tiles to the display command engine.
module grid_diff_scanner
    import grid_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int CODE_W    = 3,
    parameter int NUM_MODES = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  frame_start,
    input  logic                                                  snakeBody,
    input  logic                                                  snakeHead,
    input  logic                                                  apple,
    input  logic                                                  border,
    input  logic                                                  mode_pb,
    input  logic                                                  GameOver,
    input  logic                                                  cmd_done,
    output logic [$clog2(GRID_W)-1:0]                             x,
    output logic [$clog2(GRID_H)-1:0]                             y,
    output logic [CODE_W-1:0]                                     obj_code,
    output logic [((NUM_MODES > 1) ? $clog2(NUM_MODES) : 1)-1:0]  mode,
    output logic                                                  diff,
    output logic                                                  busy,
    output logic                                                  frame_done,
    output logic                                                  init_cycle
);

    localparam int X_W     = $clog2(GRID_W);
    localparam int Y_W     = $clog2(GRID_H);
    localparam int M_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int N_TILES = GRID_W * GRID_H;
    localparam int IDX_W   = $clog2(N_TILES);

    localparam logic [X_W-1:0]    X_LAST   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(GRID_H - 1);
    localparam logic [M_W-1:0]    M_LAST   = M_W'(NUM_MODES - 1);
    localparam logic [CODE_W-1:0] CODE_INV = CODE_W'(CODE_INVALID);

    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [CODE_W-1:0]   r_obj_code;
    logic [M_W-1:0]      r_mode;
    logic                r_diff;
    logic                r_refresh_all;
    logic                r_mode_pend;
    logic                r_init;
    logic [CODE_W-1:0]   r_buf [N_TILES];

    tile_code_t          w_enc_code;
    logic [CODE_W-1:0]   w_code;
    logic [IDX_W-1:0]    w_idx;
    logic                w_match;
    logic                w_last;
    logic                w_advance;
    logic                w_send;

    tile_encoder u_encoder (
        .i_snake_body (snakeBody),
        .i_snake_head (snakeHead),
        .i_apple      (apple),
        .i_border     (border),
        .i_game_over  (GameOver),
        .o_code       (w_enc_code)
    );

    assign w_code  = CODE_W'(w_enc_code);
    assign w_idx   = IDX_W'(int'(r_y) * GRID_W + int'(r_x));
    assign w_match = (r_buf[w_idx] == w_code) && !r_refresh_all;
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the advance/send strobes that steer the datapath.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        w_send       = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? FRAME_END : SCAN;
                end else begin
                    w_send       = 1'b1;
                    w_state_next = WAIT_CMD;
                end
            end
            WAIT_CMD: begin
                if (r_diff && cmd_done) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last ? FRAME_END : SCAN;
                end
            end
            FRAME_END: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame buffer: every entry starts as CODE_INVALID so the first pass resends all tiles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_TILES; i++) begin
                r_buf[i] <= CODE_INV;
            end
        end else if (w_send) begin
            r_buf[w_idx] <= w_code;
        end
    end

    // Coordinate, handshake, mode and refresh bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_obj_code    <= '0;
            r_mode        <= '0;
            r_diff        <= 1'b0;
            r_refresh_all <= 1'b0;
            r_mode_pend   <= 1'b0;
            r_init        <= 1'b1;
        end else begin
            // Raster advance; the final tile parks the coordinate at the origin.
            if (w_advance) begin
                if (w_last) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end

            if (w_send) begin
                r_diff     <= 1'b1;
                r_obj_code <= w_code;
            end else if (r_state == WAIT_CMD && cmd_done) begin
                r_diff <= 1'b0;
            end

            if (mode_pb) begin
                r_mode <= (r_mode == M_LAST) ? '0 : r_mode + M_W'(1);
            end

            if (r_state == FRAME_END) begin
                r_refresh_all <= 1'b0;
                r_init        <= 1'b0;
            end

            // A mode change while busy is deferred so the running pass stays consistent.
            if (r_state == IDLE) begin
                if (mode_pb) begin
                    r_refresh_all <= 1'b1;
                end
                if (frame_start && r_mode_pend) begin
                    r_refresh_all <= 1'b1;
                    r_mode_pend   <= 1'b0;
                end
            end else if (mode_pb) begin
                r_mode_pend <= 1'b1;
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign obj_code   = r_obj_code;
    assign mode       = r_mode;
    assign diff       = r_diff;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == FRAME_END);
    assign init_cycle = r_init;

endmodule

// File: tb/tb_grid_diff_scanner.sv
// Scoreboard bench for grid_diff_scanner: scenes are set up by the stimulus
// thread, expected tile transactions are queued, and a monitor checks each diff.
`timescale 1ns/1ps
module tb_grid_diff_scanner;

    typedef struct {
        int ex;
        int ey;
        int code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       mode_pb = 1'b0;
    logic       cmd_done = 1'b0;
    logic       snakeBody, snakeHead, apple, border, GameOver;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic [0:0] mode;
    logic       diff, busy, frame_done, init_cycle;

    // Scene maps indexed by {y,x}
    logic head_m   [256];
    logic body_m   [256];
    logic apple_m  [256];
    logic border_m [256];
    logic go_m = 1'b0;
    logic ack_en = 1'b1;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_diffs = 0;

    always #5 clk = ~clk;

    grid_diff_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .snakeBody  (snakeBody),
        .snakeHead  (snakeHead),
        .apple      (apple),
        .border     (border),
        .mode_pb    (mode_pb),
        .GameOver   (GameOver),
        .cmd_done   (cmd_done),
        .x          (x),
        .y          (y),
        .obj_code   (obj_code),
        .mode       (mode),
        .diff       (diff),
        .busy       (busy),
        .frame_done (frame_done),
        .init_cycle (init_cycle)
    );

    // Object decoders: combinational response to the presented coordinate
    assign snakeHead = head_m[{y, x}];
    assign snakeBody = body_m[{y, x}];
    assign apple     = apple_m[{y, x}];
    assign border    = border_m[{y, x}];
    assign GameOver  = go_m;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int scene_code(input int xx, input int yy);
        int i;
        i = yy * 16 + xx;
        if (go_m && !border_m[i]) return 5;
        if (head_m[i])   return 2;
        if (body_m[i])   return 1;
        if (apple_m[i])  return 3;
        if (border_m[i]) return 4;
        return 0;
    endfunction

    task automatic push_one(input int xx, input int yy, input int code);
        exp_t e;
        e.ex = xx; e.ey = yy; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic push_all();
        for (int yy = 0; yy < 12; yy++)
            for (int xx = 0; xx < 16; xx++)
                push_one(xx, yy, scene_code(xx, yy));
    endtask

    // Monitor: every rising diff is one tile transaction
    initial begin
        logic diff_prev;
        exp_t e;
        diff_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (diff && !diff_prev) begin
                n_diffs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_diff: got tile (%0d,%0d) code %0d, expected no diff", x, y, obj_code);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (int'(x) != e.ex || int'(y) != e.ey || int'(obj_code) != e.code) begin
                        errors++;
                        $display("FAIL diff_tile: got (%0d,%0d) code %0d, expected (%0d,%0d) code %0d",
                                 x, y, obj_code, e.ex, e.ey, e.code);
                    end else begin
                        $display("diff tile (%0d,%0d) code %0d ok", x, y, obj_code);
                    end
                end
            end
            diff_prev = diff;
        end
    end

    // Display engine model: accepts each tile 3 cycles after diff
    initial begin
        forever begin
            @(negedge clk);
            if (diff && ack_en) begin
                repeat (3) @(posedge clk);
                #1 cmd_done = 1'b1;
                @(posedge clk);
                #1 cmd_done = 1'b0;
            end
        end
    end

    task automatic run_pass(input string name, input bit with_pb, input int exp_diffs, input int exp_cycles);
        int cyc, done_at, done_cnt, guard;
        cyc = 0; done_at = -1; done_cnt = 0; guard = 0;
        n_diffs = 0;
        @(negedge clk);
        frame_start = 1'b1;
        mode_pb = with_pb;
        @(negedge clk);
        frame_start = 1'b0;
        mode_pb = 1'b0;
        while (busy && guard < 4000) begin
            cyc++;
            if (frame_done) begin
                done_cnt++;
                done_at = cyc;
            end
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected end of pass", name, guard);
        end
        chk({name, "_diffs"}, n_diffs, exp_diffs);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_frame_done_pulses"}, done_cnt, 1);
        chk({name, "_frame_done_last"}, done_at, cyc);
        if (exp_cycles > 0) chk({name, "_cycles"}, cyc, exp_cycles);
        $display("pass %s: %0d busy cycles, %0d diffs", name, cyc, n_diffs);
        exp_q.delete();
    endtask

    initial begin
        int g;
        for (int i = 0; i < 256; i++) begin
            head_m[i] = 1'b0; body_m[i] = 1'b0; apple_m[i] = 1'b0; border_m[i] = 1'b0;
        end
        for (int yy = 0; yy < 12; yy++)
            for (int xx = 0; xx < 16; xx++)
                if (xx == 0 || xx == 15 || yy == 0 || yy == 11) border_m[yy * 16 + xx] = 1'b1;
        head_m[4 * 16 + 4]  = 1'b1;
        apple_m[4 * 16 + 7] = 1'b1;

        // Reset for two edges
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_x", int'(x), 0);
        chk("reset_y", int'(y), 0);
        chk("reset_diff", int'(diff), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_init_cycle", int'(init_cycle), 1);
        chk("reset_mode", int'(mode), 0);
        chk("reset_obj_code", int'(obj_code), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;

        // First pass sends every tile
        push_all();
        run_pass("first", 1'b0, 192, 0);
        chk("init_after_first", int'(init_cycle), 0);

        // Unchanged scene: no diffs, 192 SCAN + 1 FRAME_END cycles
        run_pass("steady", 1'b0, 0, 193);

        // Head moves right, body left behind
        head_m[4 * 16 + 4] = 1'b0;
        body_m[4 * 16 + 4] = 1'b1;
        head_m[4 * 16 + 5] = 1'b1;
        push_one(4, 4, 1);
        push_one(5, 4, 2);
        run_pass("move", 1'b0, 2, 0);

        // Mode button mid-pass: current pass unaffected
        fork
            run_pass("steady_pb", 1'b0, 0, 193);
            begin
                repeat (20) @(negedge clk);
                mode_pb = 1'b1;
                @(negedge clk);
                mode_pb = 1'b0;
                chk("mode_after_pb", int'(mode), 1);
            end
        join

        // Deferred refresh from the mid-pass press
        push_all();
        run_pass("pend_refresh", 1'b0, 192, 0);

        // Mode press together with frame_start in IDLE: full refresh, mode wraps
        push_all();
        run_pass("sim_pb", 1'b1, 192, 0);
        chk("mode_wrap", int'(mode), 0);

        // Game-over fill: interior tiles only
        go_m = 1'b1;
        for (int yy = 1; yy < 11; yy++)
            for (int xx = 1; xx < 15; xx++)
                push_one(xx, yy, 5);
        run_pass("gameover", 1'b0, 140, 0);

        // Reset while waiting for cmd_done
        go_m = 1'b0;
        ack_en = 1'b0;
        push_one(1, 1, 0);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        g = 0;
        while (!diff && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("rst_test_diff_seen", int'(diff), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_busy", int'(busy), 0);
        chk("rst_wait_diff", int'(diff), 0);
        chk("rst_wait_init_cycle", int'(init_cycle), 1);
        chk("rst_wait_x", int'(x), 0);
        chk("rst_wait_y", int'(y), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_diff_scanner.md
Name: grid_diff_scanner

Overview:
- Parametrised successor to the fixed 16x12 image generator.
- Scans a GRID_W x GRID_H tile grid and drives x/y to the external object decoders.
- Encodes the returned object flags into a tile code and compares it against an internal frame buffer.
- Raises diff only for tiles that changed, then stalls until the display command engine returns cmd_done.
- Adds run-time display modes, forced full refresh and a game-over fill.

Parameters:
- GRID_W, 16, tiles per row.
- GRID_H, 12, tiles per column.
- CODE_W, 3, width of the tile code (must be at least 3).
- NUM_MODES, 2, number of display modes; mode counter wraps at this value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle strobe that starts a frame pass; ignored unless IDLE
- snakeBody  in  1  tile at current x,y is snake body; combinational response to x,y
- snakeHead  in  1  tile at current x,y is snake head
- apple  in  1  tile at current x,y is apple
- border  in  1  tile at current x,y is border
- mode_pb  in  1  one-cycle pulse that advances the display mode
- GameOver  in  1  level input, sampled per tile
- cmd_done  in  1  display engine has accepted the current tile
- x  out  $clog2(GRID_W)  current column
- y  out  $clog2(GRID_H)  current row
- obj_code  out  CODE_W  code of the tile being sent, valid while diff=1
- mode  out  $clog2(NUM_MODES) (min 1)  active display mode
- diff  out  1  tile change pending; held until cmd_done
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse at the end of each pass
- init_cycle  out  1  high from reset until the first pass completes

Behaviour:
- Reset, synchronous, rst=1 at a clk edge:
  - state=IDLE; x=0, y=0, mode=0, obj_code=0.
  - diff=0, frame_done=0, busy=0, init_cycle=1.
  - All buffer entries set to CODE_INVALID, so the first pass sends every tile.
  - refresh_all=0, mode_pend=0.
  - rst during any state aborts the pass immediately; no cmd_done is awaited.
- Tile encoding, priority order:
  - GameOver=1 and border=0 gives CODE_GAMEOVER.
  - Otherwise: snakeHead gives HEAD, else snakeBody gives BODY, else apple gives APPLE, else border gives BORDER, else EMPTY.
- IDLE:
  - frame_start=1 -> SCAN at x=0, y=0 next cycle.
  - If mode_pend=1, refresh_all is set and mode_pend is cleared at this transition.
- SCAN: one tile per cycle; the flags for the presented x,y are sampled at the same edge.
  - Code equals the buffer entry and refresh_all=0: advance the coordinate and stay in SCAN.
  - Otherwise: write the code to the buffer and to obj_code, go to WAIT_CMD, and assert diff from the next cycle.
- WAIT_CMD:
  - diff=1 and x,y are held.
  - cmd_done=1 -> diff=0 next cycle, coordinate advances, return to SCAN.
  - cmd_done while diff=0 is ignored.
- Coordinate advance:
  - x increments and wraps to 0 at GRID_W-1, at which point y increments.
  - Advancing from (GRID_W-1, GRID_H-1) goes to FRAME_END instead of SCAN.
- FRAME_END, one cycle:
  - frame_done=1, refresh_all cleared, init_cycle cleared.
  - x,y return to 0; next state IDLE.
- A pass with no changes takes exactly GRID_W*GRID_H SCAN cycles plus 1 FRAME_END cycle.
- mode_pb handling:
  - Any state: mode increments and wraps to 0 at NUM_MODES-1, effective the next cycle.
  - If busy, mode_pend=1 and the refresh is applied at the next frame_start.
  - If IDLE, refresh_all is set immediately.
  - A simultaneous mode_pb and frame_start in IDLE yields a full-refresh pass.
- A GameOver change mid-pass affects only the tiles scanned afterwards; the following pass catches up the rest.
- CODE_INVALID is never produced by the encoder.

Decomposition:
- Package grid_pkg holds:
  - the tile code enum: EMPTY=0, BODY=1, HEAD=2, APPLE=3, BORDER=4, GAMEOVER=5, INVALID=7;
  - the FSM state enum: IDLE, SCAN, WAIT_CMD, FRAME_END.
- Sub-module tile_encoder: purely combinational priority encoder from the flags and GameOver to a code.
- The frame buffer stays inline as a register array with combinational read.

Test Plan:
- Reset with rst=1 for 2 cycles -> x=0, y=0, diff=0, busy=0, init_cycle=1, mode=0.
- First pass, border on the edge ring, head at (4,4), apple at (7,4), cmd_done 3 cycles after each diff -> 192 diff assertions in raster order, obj_code=4 at (0,0), 2 at (4,4), 3 at (7,4), 0 at (1,1); init_cycle=0 after frame_done.
- Second identical pass -> 0 diffs; frame_done exactly 193 cycles after the SCAN entry.
- Head moves from (4,4) to (5,4), body placed at (4,4) -> exactly 2 diffs: (4,4) code 1, then (5,4) code 2.
- mode_pb mid-pass -> mode=1 the next cycle; current pass unaffected; next pass sends all 192 tiles; a second mode_pb gives mode=0.
- GameOver=1 for a full pass after a steady frame -> diffs on all 140 interior tiles with code 5, none on the 52 border tiles; rst asserted during WAIT_CMD -> IDLE and diff=0 the next cycle.
